ddr_port_arbiter: RTL and testbench

- Shares one MIG user command port between two masters: m0 (video line fetch) and m1 (CPU/general).
- Sits between the masters and the DDR3 controller command FIFO, in the clk_100m domain.
- Holds off all traffic until calibration is done.
- Grants one transaction at a time, issues exactly one command per grant, and holds ownership until the master signals completion or a watchdog expires.

---
 rtl/ddr_port_arbiter.sv | 126 ++++++++++++
 tb/tb_ddr_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - two-master arbiter for one MIG user command port
// Grants one transaction at a time, issues one command per grant, holds until done or watchdog.
module ddr_port_arbiter #(
  parameter int ADDR_W = 30,
  parameter int TO_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              calib_done,
  input  logic              m0_req,
  input  logic              m0_urgent,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [5:0]        m0_bl,
  input  logic              m0_done,
  output logic              m0_gnt,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [5:0]        m1_bl,
  input  logic              m1_done,
  output logic              m1_gnt,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  input  logic              cmd_full,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {WAIT_CAL, ARB, CMD, HOLD} state_t;

  state_t              state, state_nxt;
  logic                last_winner, last_winner_nxt;
  logic [TO_W-1:0]     watchdog, watchdog_nxt, watchdog_inc;
  logic                m0_gnt_nxt, m1_gnt_nxt, timeout_err_nxt;
  logic [2:0]          cmd_instr_nxt;
  logic [5:0]          cmd_bl_nxt;
  logic [ADDR_W-1:0]   cmd_byte_addr_nxt;
  logic                win0, win1, owner_done;

  // Urgent m0 overrides round-robin; last_winner only matters when both request.
  assign win0 = m0_req && (m0_urgent || !m1_req || last_winner);
  assign win1 = m1_req && !win0;
  assign owner_done = (m0_gnt && m0_done) || (m1_gnt && m1_done);
  assign watchdog_inc = watchdog + 1'b1;
  assign busy = (state != ARB);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= WAIT_CAL;
      last_winner   <= 1'b1;
      watchdog      <= '0;
      m0_gnt        <= 1'b0;
      m1_gnt        <= 1'b0;
      timeout_err   <= 1'b0;
      cmd_instr     <= 3'b000;
      cmd_bl        <= 6'd0;
      cmd_byte_addr <= '0;
    end else begin
      state         <= state_nxt;
      last_winner   <= last_winner_nxt;
      watchdog      <= watchdog_nxt;
      m0_gnt        <= m0_gnt_nxt;
      m1_gnt        <= m1_gnt_nxt;
      timeout_err   <= timeout_err_nxt;
      cmd_instr     <= cmd_instr_nxt;
      cmd_bl        <= cmd_bl_nxt;
      cmd_byte_addr <= cmd_byte_addr_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    last_winner_nxt   = last_winner;
    watchdog_nxt      = watchdog;
    m0_gnt_nxt        = m0_gnt;
    m1_gnt_nxt        = m1_gnt;
    timeout_err_nxt   = timeout_err;
    cmd_instr_nxt     = cmd_instr;
    cmd_bl_nxt        = cmd_bl;
    cmd_byte_addr_nxt = cmd_byte_addr;
    cmd_en            = 1'b0;
    case (state)
      WAIT_CAL: begin
        if (calib_done) state_nxt = ARB;
      end
      ARB: begin
        if (win0 || win1) begin
          cmd_instr_nxt     = (win0 ? m0_wr : m1_wr) ? 3'b000 : 3'b001;
          cmd_bl_nxt        = win0 ? m0_bl : m1_bl;
          cmd_byte_addr_nxt = win0 ? m0_addr : m1_addr;
          m0_gnt_nxt        = win0;
          m1_gnt_nxt        = win1;
          last_winner_nxt   = win1;
          watchdog_nxt      = '0;
          state_nxt         = CMD;
        end
      end
      CMD: begin
        cmd_en = !cmd_full;
        if (!cmd_full) state_nxt = HOLD;
      end
      HOLD: begin
        watchdog_nxt = watchdog_inc;
        if (owner_done || watchdog_inc == {TO_W{1'b1}}) begin
          if (!owner_done) timeout_err_nxt = 1'b1;
          m0_gnt_nxt   = 1'b0;
          m1_gnt_nxt   = 1'b0;
          watchdog_nxt = '0;
          state_nxt    = ARB;
        end
      end
      default: state_nxt = WAIT_CAL;
    endcase
    // Losing calibration aborts ownership from any state; an issued command stays issued.
    if (!calib_done) begin
      state_nxt    = WAIT_CAL;
      m0_gnt_nxt   = 1'b0;
      m1_gnt_nxt   = 1'b0;
      watchdog_nxt = '0;
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - directed self-checking bench for ddr_port_arbiter
module tb_ddr_port_arbiter;

  logic        sys_clk, sys_rst, calib_done;
  logic        m0_req, m0_urgent, m0_wr, m0_done, m0_gnt;
  logic [29:0] m0_addr, m1_addr, cmd_byte_addr;
  logic [5:0]  m0_bl, m1_bl, cmd_bl;
  logic        m1_req, m1_wr, m1_done, m1_gnt;
  logic        cmd_en, cmd_full, busy, timeout_err;
  logic [2:0]  cmd_instr;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;

  ddr_port_arbiter #(.ADDR_W(30), .TO_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .calib_done(calib_done),
    .m0_req(m0_req), .m0_urgent(m0_urgent), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_bl(m0_bl), .m0_done(m0_done), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_bl(m1_bl),
    .m1_done(m1_done), .m1_gnt(m1_gnt),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (m0_gnt && m1_gnt) both_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic serve(output logic who, output logic [2:0] ins,
                       output logic [5:0] bl, output logic [29:0] ad);
    int n;
    n = 0;
    while (!cmd_en && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_en_seen", 32'(cmd_en), 1);
    who = m1_gnt;
    ins = cmd_instr;
    bl  = cmd_bl;
    ad  = cmd_byte_addr;
    tick();
    chk("single_cmd_en", 32'(cmd_en), 0);
    repeat (4) tick();
    if (who) m1_done = 1'b1;
    else     m0_done = 1'b1;
    tick();
    m0_done = 1'b0;
    m1_done = 1'b0;
    chk("gnt_drop", 32'(m0_gnt | m1_gnt), 0);
  endtask

  initial begin
    logic        who;
    logic [2:0]  ins;
    logic [5:0]  bl;
    logic [29:0] ad;
    int          n;

    sys_rst = 1'b1; calib_done = 1'b0; cmd_full = 1'b0;
    m0_req = 1'b1; m0_urgent = 1'b0; m0_wr = 1'b0; m0_addr = 30'h1234; m0_bl = 6'd7; m0_done = 1'b0;
    m1_req = 1'b0; m1_wr = 1'b1; m1_addr = 30'h100; m1_bl = 6'd15; m1_done = 1'b0;
    repeat (3) tick();
    sys_rst = 1'b0;
    chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 0);
    chk("rst_cmd_en", 32'(cmd_en), 0);
    chk("rst_addr", 32'(cmd_byte_addr), 0);
    chk("rst_timeout", 32'(timeout_err), 0);

    n = 0;
    repeat (100) begin
      tick();
      if (m0_gnt || m1_gnt || cmd_en) n++;
    end
    chk("precal_quiet", n, 0);

    calib_done = 1'b1;
    tick();
    chk("cal_gnt_plus1", 32'(m0_gnt), 0);
    tick();
    chk("cal_gnt_plus2", 32'(m0_gnt), 1);
    chk("cal_cmd_en", 32'(cmd_en), 1);
    chk("cal_instr", 32'(cmd_instr), 32'h1);
    chk("cal_addr", 32'(cmd_byte_addr), 32'h1234);
    chk("cal_bl", 32'(cmd_bl), 7);
    m0_req = 1'b0;
    tick();
    chk("cal_cmd_once", 32'(cmd_en), 0);
    m0_done = 1'b1;
    tick();
    m0_done = 1'b0;
    chk("cal_gnt_drop", 32'(m0_gnt), 0);
    chk("idle_busy", 32'(busy), 0);

    // Contention: m0 won last, so round-robin starts with m1.
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 30'h2000; m0_bl = 6'd3;
    serve(who, ins, bl, ad);
    chk("rr0_who", 32'(who), 1);
    chk("rr0_instr", 32'(ins), 0);
    chk("rr0_bl", 32'(bl), 15);
    chk("rr0_addr", 32'(ad), 32'h100);
    serve(who, ins, bl, ad);
    chk("rr1_who", 32'(who), 0);
    chk("rr1_instr", 32'(ins), 1);
    chk("rr1_addr", 32'(ad), 32'h2000);
    serve(who, ins, bl, ad);
    chk("rr2_who", 32'(who), 1);
    serve(who, ins, bl, ad);
    chk("rr3_who", 32'(who), 0);

    m0_urgent = 1'b1;
    serve(who, ins, bl, ad);
    chk("urgent_who", 32'(who), 0);
    m0_urgent = 1'b0;
    serve(who, ins, bl, ad);
    chk("post_urgent_who", 32'(who), 1);

    // Stall longer than the watchdog period; it must not count in CMD.
    m1_req = 1'b0; cmd_full = 1'b1;
    tick();
    chk("stall_gnt", 32'(m0_gnt), 1);
    m0_req = 1'b0;
    n = 0;
    repeat (19) begin
      tick();
      if (cmd_en) n++;
    end
    chk("stall_no_cmd_en", n, 0);
    cmd_full = 1'b0;
    #1;
    chk("stall_release", 32'(cmd_en), 1);
    tick();
    chk("stall_single", 32'(cmd_en), 0);
    m1_done = 1'b1;
    tick();
    m1_done = 1'b0;
    chk("other_done_ignored", 32'(m0_gnt), 1);
    repeat (8) tick();
    chk("stall_no_timeout", 32'(timeout_err), 0);
    chk("stall_still_gnt", 32'(m0_gnt), 1);
    m0_done = 1'b1;
    tick();
    m0_done = 1'b0;
    chk("stall_gnt_drop", 32'(m0_gnt), 0);

    m0_req = 1'b1;
    tick();
    chk("to_cmd_en", 32'(cmd_en), 1);
    m0_req = 1'b0; m1_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (m0_gnt && n < 40);
    chk("to_cycles", n, 16);
    chk("to_err_set", 32'(timeout_err), 1);
    tick();
    chk("to_other_gnt", 32'(m1_gnt), 1);
    m1_req = 1'b0;
    tick();
    chk("to_err_sticky", 32'(timeout_err), 1);

    calib_done = 1'b0;
    tick();
    chk("cal_drop_gnt", 32'(m1_gnt), 0);
    chk("cal_drop_busy", 32'(busy), 1);
    m1_req = 1'b1;
    tick();
    chk("cal_low_no_gnt", 32'(m1_gnt), 0);
    calib_done = 1'b1; cmd_full = 1'b1;
    tick();
    chk("recal_plus1", 32'(m1_gnt), 0);
    tick();
    chk("recal_plus2", 32'(m1_gnt), 1);
    sys_rst = 1'b1; cmd_full = 1'b0;
    tick();
    chk("midcmd_rst_gnt", 32'({m0_gnt, m1_gnt}), 0);
    chk("midcmd_rst_cmd_en", 32'(cmd_en), 0);
    chk("midcmd_rst_timeout", 32'(timeout_err), 0);
    chk("midcmd_rst_fields", 32'({cmd_instr, cmd_bl, cmd_byte_addr[22:0]}), 0);
    chk("midcmd_rst_addr_hi", 32'(cmd_byte_addr[29:23]), 0);

    chk("both_gnt", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
